branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
// Parametrised next-PC predictor and resolver for the fetch/execute loop. Fetch side: direct-mapped
// BTB with per-entry 2-bit saturating counters; predicts taken/target for the current fetch PC.
// Execute side: resolves the real outcome from the ALU zero flag and funct3, drives next_pc_select,
// flags mispredictions, trains the table. Sits between the PC register and the execute stage.
// PARAMETERS
// XLEN        32    address width
// ENTRIES     64    BTB/counter entries; power of 2, >= 2
// CTR_INIT    2'b01 counter reset/allocate value (weakly not-taken)
// IDX = $clog2(ENTRIES); index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]
// PORTS
// clock               in   1     clock
// reset_n             in   1     asynchronous reset, active low
// flush               in   1     sync: clear all entry valid bits
// fetch_pc            in   XLEN  PC being fetched
// predict_taken       out  1     hit & (uncond | ctr[1])
// predict_target      out  XLEN  stored target on hit, else fetch_pc+4
// resolve_valid       in   1     execute-stage instruction valid
// resolve_pc          in   XLEN  PC of resolving instruction
// branch_enable       in   1     conditional branch
// jal_enable          in   1     JAL
// jalr_enable         in   1     JALR
// inst_funct3         in   3     branch funct3
// result_equal_zero   in   1     ALU compare result == 0
// resolve_target      in   XLEN  computed target (JALR already bit0-cleared)
// resolve_pred_taken  in   1     prediction carried down pipeline
// resolve_pred_target in   XLEN  predicted target carried down pipeline
// next_pc_select      out  2     00 PC+4, 01 PC+imm, 10 JALR target
// mispredict          out  1     redirect fetch this cycle
// mispredict_count    out  32    saturating mispredict statistic
// BEHAVIOUR
// - Lookup combinational from registered table; zero latency. No bypass: same-cycle update to the
//   looked-up index is visible next cycle only.
// - Taken: EQ/GE/GEU taken iff result_equal_zero; NE/LT/LTU taken iff !result_equal_zero;
//   funct3 010/011 never taken. JAL/JALR always taken. Priority branch > jal > jalr.
// - next_pc_select: 01 branch taken or JAL, 10 JALR, else 00; forced 00 when !resolve_valid.
// - mispredict = resolve_valid & (taken != resolve_pred_taken | (taken &
//   resolve_target != resolve_pred_target)). Non-control instr predicted taken -> mispredict.
// - Update on clock edge when resolve_valid, at index(resolve_pc):
//   hit & branch: ctr saturating +1 if taken, -1 if not (11 stays 11, 00 stays 00); target updated if taken.
//   miss & taken branch: allocate valid=1, tag, target, uncond=0, ctr=2'b10.
//   miss & not-taken branch: no change.
//   JAL/JALR: write valid, tag, target, uncond=1, ctr=2'b11 (hit or miss).
//   hit & non-control instr: invalidate entry (aliased stale entry).
// - flush: all valid<=0 next edge; flush wins over simultaneous update to any entry.
// - mispredict_count: +1 per mispredict cycle, saturates at 32'hFFFF_FFFF; not cleared by flush.
// - Reset (async, any time incl. mid-update): valid=0, ctr=CTR_INIT, uncond=0, tags/targets=0,
//   mispredict_count=0. Outputs during reset: predict_taken=0, predict_target=fetch_pc+4;
//   next_pc_select/mispredict per combinational inputs (0 when resolve_valid=0).
// TESTING
// - Reset, fetch_pc=0x100 -> predict_taken=0, predict_target=0x104; count=0.
// - BEQ at 0x200 zero=1 target 0x240, pred 0 -> mispredict=1, sel=01; next fetch 0x200 ->
//   taken=1, target=0x240; 2x not-taken -> ctr 10->01->00, predict_taken=0.
// - JALR at 0x300 target 0x1001 clr->0x1000 -> sel=10; refetch 0x300 -> taken=1 target 0x1000.
// - ENTRIES=64: 0x200 and 0x300 (same index) alias -> tag miss, predict_taken=0.
// - Lookup+update same index same cycle -> old value; flush+update same edge -> entry invalid.
// - Force 2^32 mispredicts (preload) -> count stays 32'hFFFF_FFFF; reset_n low mid-run -> all clear.

Source files
------------

// File: rtl/branch_predictor.sv
// Next-PC predictor: direct-mapped BTB with 2-bit counters on the fetch side,
// branch resolution, mispredict detection and table training on the execute side.
module branch_predictor #(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 64,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            predict_taken,
    output logic [XLEN-1:0] predict_target,
    input  logic            resolve_valid,
    input  logic [XLEN-1:0] resolve_pc,
    input  logic            branch_enable,
    input  logic            jal_enable,
    input  logic            jalr_enable,
    input  logic [2:0]      inst_funct3,
    input  logic            result_equal_zero,
    input  logic [XLEN-1:0] resolve_target,
    input  logic            resolve_pred_taken,
    input  logic [XLEN-1:0] resolve_pred_target,
    output logic [1:0]      next_pc_select,
    output logic            mispredict,
    output logic [31:0]     mispredict_count
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = XLEN - IDX - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] uncond_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TW-1:0]      tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];
    logic [31:0]        mis_cnt_q, mis_cnt_d;

    logic [IDX-1:0] f_idx, r_idx;
    logic [TW-1:0]  f_tag, r_tag;
    logic           f_hit, r_hit;

    logic           br_taken, taken;

    logic            ent_we;
    logic            ent_valid_d;
    logic            ent_uncond_d;
    logic [1:0]      ent_ctr_d;
    logic [XLEN-1:0] ent_tgt_d;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], resolve_pc[1:0]};

    assign f_idx = fetch_pc[IDX+1:2];
    assign f_tag = fetch_pc[XLEN-1:IDX+2];
    assign r_idx = resolve_pc[IDX+1:2];
    assign r_tag = resolve_pc[XLEN-1:IDX+2];

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    assign predict_taken  = f_hit && (uncond_q[f_idx] || ctr_q[f_idx][1]);
    assign predict_target = f_hit ? tgt_q[f_idx] : fetch_pc + XLEN'(4);

    always_comb begin
        br_taken = 1'b0;
        case (inst_funct3)
            3'b000, 3'b101, 3'b111: br_taken = result_equal_zero;
            3'b001, 3'b100, 3'b110: br_taken = !result_equal_zero;
            default:                br_taken = 1'b0;
        endcase
    end

    assign taken = branch_enable ? br_taken : (jal_enable || jalr_enable);

    always_comb begin
        next_pc_select = 2'b00;
        if (resolve_valid) begin
            if (branch_enable) begin
                next_pc_select = br_taken ? 2'b01 : 2'b00;
            end else if (jal_enable) begin
                next_pc_select = 2'b01;
            end else if (jalr_enable) begin
                next_pc_select = 2'b10;
            end
        end
    end

    assign mispredict = resolve_valid &&
        ((taken != resolve_pred_taken) ||
         (taken && (resolve_target != resolve_pred_target)));

    assign mis_cnt_d = (mispredict && (mis_cnt_q != 32'hFFFF_FFFF))
                     ? mis_cnt_q + 32'd1 : mis_cnt_q;
    assign mispredict_count = mis_cnt_q;

    always_comb begin
        ent_we       = 1'b0;
        ent_valid_d  = valid_q[r_idx];
        ent_uncond_d = uncond_q[r_idx];
        ent_ctr_d    = ctr_q[r_idx];
        ent_tgt_d    = tgt_q[r_idx];
        if (resolve_valid) begin
            if (branch_enable) begin
                if (r_hit) begin
                    ent_we = 1'b1;
                    if (br_taken) begin
                        ent_tgt_d = resolve_target;
                        if (ctr_q[r_idx] != 2'b11) ent_ctr_d = ctr_q[r_idx] + 2'd1;
                    end else if (ctr_q[r_idx] != 2'b00) begin
                        ent_ctr_d = ctr_q[r_idx] - 2'd1;
                    end
                end else if (br_taken) begin
                    ent_we       = 1'b1;
                    ent_valid_d  = 1'b1;
                    ent_uncond_d = 1'b0;
                    ent_ctr_d    = 2'b10;
                    ent_tgt_d    = resolve_target;
                end
            end else if (jal_enable || jalr_enable) begin
                ent_we       = 1'b1;
                ent_valid_d  = 1'b1;
                ent_uncond_d = 1'b1;
                ent_ctr_d    = 2'b11;
                ent_tgt_d    = resolve_target;
            end else if (r_hit) begin
                // stale entry aliased onto a non-control instruction
                ent_we      = 1'b1;
                ent_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= '0;
            uncond_q  <= '0;
            mis_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            mis_cnt_q <= mis_cnt_d;
            if (ent_we) begin
                valid_q[r_idx]  <= ent_valid_d;
                uncond_q[r_idx] <= ent_uncond_d;
                ctr_q[r_idx]    <= ent_ctr_d;
                tag_q[r_idx]    <= r_tag;
                tgt_q[r_idx]    <= ent_tgt_d;
            end
            if (flush) valid_q <= '0;
        end
    end

endmodule
